ofm_upsample_writer: RTL and testbench

// - Last stage before the OFM dual-port RAM. Takes conv/maxpool result pixels from the output FIFO and writes them to OFM RAM.
// - Input order is filter-major, then row-major: (filter, row, col).
// - With upsample_mode=1 each pixel is written to its 2x2 nearest-neighbour footprint, giving a 2S x 2S plane per filter.
// - With upsample_mode=0 pixels are written 1:1.

---
 rtl/ofm_wr_pkg.sv | 16 +
 rtl/ofm_upsample_writer_addr_gen.sv | 103 ++++++++++
 rtl/ofm_upsample_writer.sv | 175 +++++++++++++++++
 tb/tb_ofm_upsample_writer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_wr_pkg.sv
// Shared types for the OFM upsample writer: FSM states, DUP phase index and
// the width of the output-plane side length.
package ofm_wr_pkg;

   localparam int OFM_DIM_W = 10;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DUP,
      FIN
   } state_t;

   typedef logic [1:0] phase_t;

endpackage

// File: rtl/ofm_upsample_writer_addr_gen.sv
// Address generator for the OFM writer: walks (filter, row, col) with running
// accumulators only and offsets the current pixel base by the 2x2 phase.
module ofm_addr_gen
   import ofm_wr_pkg::*;
#(
   parameter int ADDR_WIDTH = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init,
   input  logic                  advance,
   input  logic                  mode,
   input  logic [8:0]            s,
   input  logic [10:0]           f,
   input  logic [OFM_DIM_W-1:0]  o,
   input  phase_t                phase,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last
);

   logic [8:0]            col_q, col_d;
   logic [8:0]            row_q, row_d;
   logic [10:0]           filt_q, filt_d;
   logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
   logic [ADDR_WIDTH-1:0] col_off_q, col_off_d;

   logic [ADDR_WIDTH-1:0] o_ext;
   logic [ADDR_WIDTH-1:0] row_step;
   logic [ADDR_WIDTH-1:0] col_step;
   logic [ADDR_WIDTH-1:0] phase_off;
   logic                  col_last;
   logic                  row_last;
   logic                  filt_last;

   assign o_ext     = ADDR_WIDTH'(o);
   assign row_step  = mode ? {o_ext[ADDR_WIDTH-2:0], 1'b0} : o_ext;
   assign col_step  = {{(ADDR_WIDTH-2){1'b0}}, mode, ~mode};
   assign col_last  = (col_q == 9'(s - 9'd1));
   assign row_last  = (row_q == 9'(s - 9'd1));
   assign filt_last = (filt_q == 11'(f - 11'd1));
   assign last      = col_last && row_last && filt_last;

   always_comb begin
      phase_off = '0;
      case (phase)
         2'd1:    phase_off = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
         2'd2:    phase_off = o_ext;
         2'd3:    phase_off = o_ext + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
         default: phase_off = '0;
      endcase
   end

   assign addr = row_base_q + col_off_q + phase_off;

   // The plane base is never stored separately: after the last row of a plane
   // the row base has advanced by exactly O*O (or S*S), which is the next plane.
   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      filt_d     = filt_q;
      row_base_d = row_base_q;
      col_off_d  = col_off_q;
      if (init) begin
         col_d      = '0;
         row_d      = '0;
         filt_d     = '0;
         row_base_d = '0;
         col_off_d  = '0;
      end else if (advance) begin
         if (col_last) begin
            col_d      = '0;
            col_off_d  = '0;
            row_base_d = row_base_q + row_step;
            if (row_last) begin
               row_d  = '0;
               filt_d = filt_q + 11'd1;
            end else begin
               row_d = row_q + 9'd1;
            end
         end else begin
            col_d     = col_q + 9'd1;
            col_off_d = col_off_q + col_step;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q      <= '0;
         row_q      <= '0;
         filt_q     <= '0;
         row_base_q <= '0;
         col_off_q  <= '0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         filt_q     <= filt_d;
         row_base_q <= row_base_d;
         col_off_q  <= col_off_d;
      end
   end

endmodule

// File: rtl/ofm_upsample_writer.sv
// Writes conv/pool output pixels to OFM RAM, 1:1 or as 2x2 nearest-neighbour
// footprints. Optional sticky out-of-bounds flag under OFM_BOUND_CHECK_EN.
module ofm_upsample_writer
   import ofm_wr_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 20,
   parameter int OFM_RAM_SIZE = 692224
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [8:0]            ofm_size_conv,
   input  logic [10:0]           num_filter,
   input  logic                  upsample_mode,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  done
`ifdef OFM_BOUND_CHECK_EN
   ,
   output logic                  err_oob
`endif
);

   if (longint'(OFM_RAM_SIZE) > (longint'(1) <<< ADDR_WIDTH)) begin : g_size_check
      $error("OFM_RAM_SIZE does not fit in ADDR_WIDTH");
   end

   state_t                 state_q, state_d;
   phase_t                 phase_q, phase_d;
   logic [8:0]             s_q, s_d;
   logic [10:0]            f_q, f_d;
   logic                   mode_q, mode_d;
   logic [OFM_DIM_W-1:0]   o_q, o_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
   logic                   done_q, done_d;

   logic                   gen_init;
   logic                   gen_advance;
   logic [ADDR_WIDTH-1:0]  gen_addr;
   logic                   gen_last;

   ofm_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .init    (gen_init),
      .advance (gen_advance),
      .mode    (mode_q),
      .s       (s_q),
      .f       (f_q),
      .o       (o_q),
      .phase   (phase_q),
      .addr    (gen_addr),
      .last    (gen_last)
   );

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      s_d         = s_q;
      f_d         = f_q;
      mode_d      = mode_q;
      o_d         = o_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      done_d      = (state_q == FIN);
      gen_init    = 1'b0;
      gen_advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               s_d      = ofm_size_conv;
               f_d      = num_filter;
               mode_d   = upsample_mode;
               o_d      = upsample_mode ? {ofm_size_conv, 1'b0} : {1'b0, ofm_size_conv};
               phase_d  = 2'd0;
               gen_init = 1'b1;
               state_d  = (ofm_size_conv == 9'd0 || num_filter == 11'd0) ? FIN : RUN;
            end
         end
         RUN: begin
            if (in_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = gen_addr;
               wr_data_d = in_data;
               if (mode_q) begin
                  state_d = DUP;
                  phase_d = 2'd1;
               end else begin
                  gen_advance = 1'b1;
                  if (gen_last) state_d = FIN;
               end
            end
         end
         // wr_data_q still holds the accepted pixel for the remaining phases.
         DUP: begin
            wr_en_d   = 1'b1;
            wr_addr_d = gen_addr;
            phase_d   = phase_t'(phase_q + 2'd1);
            if (phase_q == 2'd3) begin
               gen_advance = 1'b1;
               phase_d     = 2'd0;
               state_d     = gen_last ? FIN : RUN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         phase_q   <= 2'd0;
         s_q       <= '0;
         f_q       <= '0;
         mode_q    <= 1'b0;
         o_q       <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         s_q       <= s_d;
         f_q       <= f_d;
         mode_q    <= mode_d;
         o_q       <= o_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
      end
   end

   assign in_ready = (state_q == RUN);
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign done     = done_q;

`ifdef OFM_BOUND_CHECK_EN
   localparam logic [ADDR_WIDTH:0] RAM_LIMIT = (ADDR_WIDTH+1)'(OFM_RAM_SIZE);

   logic err_q, err_d;

   // Flags the write already on the RAM port; the write itself is never blocked.
   always_comb begin
      err_d = err_q | (wr_en_q && ({1'b0, wr_addr_q} >= RAM_LIMIT));
      if (state_q == IDLE && start) err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err_oob = err_q;
`endif

endmodule

// File: tb/tb_ofm_upsample_writer.sv
// Self-checking bench for ofm_upsample_writer: table of jobs plus randomized
// jobs checked against an arithmetic (filter,row,col) address model.
module tb_ofm_upsample_writer;

   localparam int DW = 16;
   localparam int AW = 20;
`ifdef OFM_BOUND_CHECK_EN
   localparam int RAM_SZ = 600;
`else
   localparam int RAM_SZ = 692224;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [8:0]    ofm_size_conv = '0;
   logic [10:0]   num_filter = '0;
   logic          upsample_mode = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          done;
`ifdef OFM_BOUND_CHECK_EN
   logic          err_oob;
`endif

   ofm_upsample_writer #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .OFM_RAM_SIZE (RAM_SZ)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .ofm_size_conv (ofm_size_conv),
      .num_filter    (num_filter),
      .upsample_mode (upsample_mode),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .done          (done)
`ifdef OFM_BOUND_CHECK_EN
      ,
      .err_oob       (err_oob)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      int s;
      int f;
      bit mode;
      int gap;
      int glitch;
      int exp_writes;
   } job_t;

   typedef struct {
      int idx;
      int addr;
      int data;
   } spot_t;

   int  vectors = 0;
   int  miscompares = 0;
   int  cyc = 0;
   wr_t got_q[$];
   int  first_wr_cyc, last_wr_cyc, done_count, done_cyc, start_cyc;
   int  err_rise_cyc, cyc600;
   bit  err_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observes the RAM port away from the active edge.
   always @(negedge clk) begin
      if (wr_en) begin
         if (got_q.size() == 0) first_wr_cyc = cyc;
         got_q.push_back(wr_t'{addr: wr_addr, data: wr_data});
         last_wr_cyc = cyc;
         if (int'(wr_addr) == 600) cyc600 = cyc;
      end
      if (done) begin
         done_count++;
         done_cyc = cyc;
      end
`ifdef OFM_BOUND_CHECK_EN
      if (err_oob && !err_prev) err_rise_cyc = cyc;
      err_prev = err_oob;
`endif
   end

   initial begin
      wait (cyc > 90000);
      $display("[TB] FAIL watchdog: got cycle %0d, required < 90000", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Runs one job; abort_after >= 0 stops feeding after that many pixels.
   task automatic applyStimulus(input int s, input int f, input bit mode, input int gap,
                                input int glitch, input bit rand_data, input int exp_writes,
                                input int abort_after);
      wr_t           exp_q[$];
      logic [DW-1:0] pix[$];
      int            n = s * s * f;
      int            dup_bad = 0;
      int            stalls = 0;
      int            budget;
      int            o;
      int            b;
      logic [DW-1:0] d;

      @(negedge clk);
      got_q.delete();
      done_count    = 0;
      ofm_size_conv = 9'(s);
      num_filter    = 11'(f);
      upsample_mode = mode;
      start         = 1'b1;
      start_cyc     = cyc;
      @(negedge clk);
      start = 1'b0;

      for (int k = 0; k < n; k++) begin
         if (k == abort_after) begin
            in_valid = 1'b0;
            return;
         end
         d = rand_data ? DW'($urandom) : DW'(k);
         pix.push_back(d);
         for (int g = 0; g < ((gap == 2) ? int'($urandom_range(0, 2)) : gap); g++) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = d;
         if (k == glitch) begin
            start         = 1'b1;
            ofm_size_conv = 9'(s + 2);
            num_filter    = 11'(f + 1);
            upsample_mode = !mode;
         end
         budget = 0;
         while (!in_ready && budget < 20) begin
            stalls++;
            budget++;
            @(negedge clk);
         end
         if (budget >= 20) begin
            checkOutput("accept_timeout", 0, 1);
            in_valid = 1'b0;
            start    = 1'b0;
            return;
         end
         @(negedge clk);
         in_valid      = 1'b0;
         start         = 1'b0;
         ofm_size_conv = 9'(s);
         num_filter    = 11'(f);
         upsample_mode = mode;
         if (mode) begin
            for (int j = 0; j < 3; j++) begin
               if (in_ready) dup_bad++;
               @(negedge clk);
            end
         end
      end

      budget = 0;
      while (done_count == 0 && budget < 200) begin
         budget++;
         @(posedge clk);
      end
      repeat (3) @(negedge clk);

      for (int ff = 0; ff < f; ff++)
         for (int r = 0; r < s; r++)
            for (int c = 0; c < s; c++) begin
               int k = (ff * s + r) * s + c;
               if (!mode) begin
                  exp_q.push_back(wr_t'{addr: AW'(k), data: pix[k]});
               end else begin
                  o = 2 * s;
                  b = ff * o * o + 2 * r * o + 2 * c;
                  exp_q.push_back(wr_t'{addr: AW'(b), data: pix[k]});
                  exp_q.push_back(wr_t'{addr: AW'(b + 1), data: pix[k]});
                  exp_q.push_back(wr_t'{addr: AW'(b + o), data: pix[k]});
                  exp_q.push_back(wr_t'{addr: AW'(b + o + 1), data: pix[k]});
               end
            end

      checkOutput("done_count", done_count, 1);
      checkOutput("write_count", got_q.size(), (exp_writes >= 0) ? exp_writes : exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checkOutput($sformatf("wr_addr[%0d]", i), got_q[i].addr, exp_q[i].addr);
         checkOutput($sformatf("wr_data[%0d]", i), got_q[i].data, exp_q[i].data);
      end
      if (n > 0) checkOutput("done_after_last_write", done_cyc - last_wr_cyc, 1);
      else       checkOutput("done_after_start", done_cyc - start_cyc, 2);
      if (n > 0 && gap == 0)
         checkOutput("write_span", last_wr_cyc - first_wr_cyc, mode ? 4 * n - 1 : n - 1);
      if (mode) checkOutput("in_ready_in_dup", dup_bad, 0);
      if (!mode && gap == 0) checkOutput("in_ready_stalls", stalls, 0);
   endtask

   job_t  jobs[8];
   spot_t spots[16];
   int    small_order[16];

   initial begin
      jobs[0] = '{s: 13, f: 16, mode: 1'b1, gap: 0, glitch: -1, exp_writes: 10816};
      jobs[1] = '{s: 13, f: 16, mode: 1'b0, gap: 0, glitch: -1, exp_writes: 2704};
      jobs[2] = '{s: 13, f: 16, mode: 1'b1, gap: 1, glitch: -1, exp_writes: 10816};
      jobs[3] = '{s: 3,  f: 2,  mode: 1'b0, gap: 0, glitch: 5,  exp_writes: 18};
      jobs[4] = '{s: 13, f: 0,  mode: 1'b1, gap: 0, glitch: -1, exp_writes: 0};
      jobs[5] = '{s: 0,  f: 4,  mode: 1'b0, gap: 0, glitch: -1, exp_writes: 0};
      jobs[6] = '{s: 1,  f: 1,  mode: 1'b1, gap: 0, glitch: -1, exp_writes: 4};
      jobs[7] = '{s: 2,  f: 3,  mode: 1'b1, gap: 0, glitch: 1,  exp_writes: 48};

      spots[0]  = '{idx: 0,   addr: 0,   data: 0};
      spots[1]  = '{idx: 1,   addr: 1,   data: 0};
      spots[2]  = '{idx: 2,   addr: 26,  data: 0};
      spots[3]  = '{idx: 3,   addr: 27,  data: 0};
      spots[4]  = '{idx: 4,   addr: 2,   data: 1};
      spots[5]  = '{idx: 5,   addr: 3,   data: 1};
      spots[6]  = '{idx: 6,   addr: 28,  data: 1};
      spots[7]  = '{idx: 7,   addr: 29,  data: 1};
      spots[8]  = '{idx: 52,  addr: 52,  data: 13};
      spots[9]  = '{idx: 53,  addr: 53,  data: 13};
      spots[10] = '{idx: 54,  addr: 78,  data: 13};
      spots[11] = '{idx: 55,  addr: 79,  data: 13};
      spots[12] = '{idx: 676, addr: 676, data: 169};
      spots[13] = '{idx: 677, addr: 677, data: 169};
      spots[14] = '{idx: 678, addr: 702, data: 169};
      spots[15] = '{idx: 679, addr: 703, data: 169};

      small_order = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

      repeat (3) @(negedge clk);
      checkOutput("reset_in_ready", in_ready, 0);
      checkOutput("reset_wr_en", wr_en, 0);
      checkOutput("reset_wr_addr", wr_addr, 0);
      checkOutput("reset_wr_data", wr_data, 0);
      checkOutput("reset_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_in_ready", in_ready, 0);

      for (int j = 0; j < 8; j++) begin
         $display("[TB] job %0d: S=%0d F=%0d mode=%0d gap=%0d", j, jobs[j].s, jobs[j].f,
                  jobs[j].mode, jobs[j].gap);
         applyStimulus(jobs[j].s, jobs[j].f, jobs[j].mode, jobs[j].gap, jobs[j].glitch,
                       1'b0, jobs[j].exp_writes, -1);
         if (jobs[j].s == 13 && jobs[j].mode && jobs[j].f == 16) begin
            for (int i = 0; i < 16; i++) begin
               if (spots[i].idx < got_q.size()) begin
                  checkOutput($sformatf("spot_addr[%0d]", spots[i].idx),
                              got_q[spots[i].idx].addr, spots[i].addr);
                  checkOutput($sformatf("spot_data[%0d]", spots[i].idx),
                              got_q[spots[i].idx].data, spots[i].data);
               end else begin
                  checkOutput($sformatf("spot_missing[%0d]", spots[i].idx), got_q.size(),
                              spots[i].idx + 1);
               end
            end
         end
      end

      $display("[TB] mid-job reset");
      applyStimulus(13, 16, 1'b1, 0, -1, 1'b0, -1, 100);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_in_ready", in_ready, 0);
      checkOutput("abort_wr_en", wr_en, 0);
      checkOutput("abort_wr_addr", wr_addr, 0);
      checkOutput("abort_wr_data", wr_data, 0);
      checkOutput("abort_done", done, 0);
      rst = 1'b0;
      got_q.delete();
      repeat (5) @(negedge clk);
      checkOutput("abort_no_writes", got_q.size(), 0);
      applyStimulus(2, 1, 1'b1, 0, -1, 1'b0, 16, -1);
      for (int i = 0; i < 16 && i < got_q.size(); i++)
         checkOutput($sformatf("small_order[%0d]", i), got_q[i].addr, small_order[i]);

      $display("[TB] random jobs");
      for (int t = 0; t < 12; t++) begin
         applyStimulus(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1, 1'b1, -1, -1);
      end

`ifdef OFM_BOUND_CHECK_EN
      $display("[TB] bound check");
      err_rise_cyc = -1;
      cyc600       = -1;
      applyStimulus(13, 1, 1'b1, 0, -1, 1'b0, 676, -1);
      checkOutput("err_rise_after_600", err_rise_cyc - cyc600, 1);
      checkOutput("err_sticky", err_oob, 1);
      applyStimulus(13, 0, 1'b1, 0, -1, 1'b0, 0, -1);
      checkOutput("err_cleared_by_start", err_oob, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
